seq_play_core: RTL and testbench

- Single-clock sequence player: bus-loaded pattern memory is replayed word-by-word onto a parallel output after a bus or external start.
- Transmit-side counterpart of the sequence recorder. Used to drive stimulus patterns into DUT inputs that the recorder then captures.
- Sits on the standard 8-bit SiLab register bus: 16 control registers, then the pattern memory.

---
 rtl/seq_play_pkg.sv | 27 ++
 rtl/seq_play_mem.sv | 33 +++
 rtl/seq_play_core.sv | 162 ++++++++++++++++
 tb/tb_seq_play_core.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_play_pkg.sv
// rtl/seq_play_pkg.sv - register map, version and sizing helpers for the sequence player
package seq_play_pkg;

  localparam int REG_VERSION  = 0;
  localparam int REG_START    = 1;
  localparam int REG_CONF     = 2;
  localparam int REG_COUNT_L  = 3;
  localparam int REG_COUNT_H  = 4;
  localparam int REG_REPEAT_L = 5;
  localparam int REG_REPEAT_H = 6;
  localparam int REG_SCR_LO   = 7;
  localparam int REG_SCR_HI   = 15;
  localparam int MEM_BASE     = 16;

  localparam logic [7:0] VERSION = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } play_state_t;

  function automatic int calc_words(input int mem_bytes, input int out_bits);
    return mem_bytes * 8 / out_bits;
  endfunction

endpackage

// File: rtl/seq_play_mem.sv
// rtl/seq_play_mem.sv - dual-port pattern RAM: byte bus port, big-endian word play port
module seq_play_mem #(
  parameter int MEM_BYTES = 8 * 1024,
  parameter int OUT_BITS  = 8,
  localparam int BAW   = $clog2(MEM_BYTES),
  localparam int LANES = OUT_BITS / 8,
  localparam int WORDS = MEM_BYTES / LANES,
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                clk,
  input  logic                a_we,
  input  logic [BAW-1:0]      a_addr,
  input  logic [7:0]          a_wdata,
  output logic [7:0]          a_rdata,
  input  logic [WAW-1:0]      b_addr,
  output logic [OUT_BITS-1:0] b_rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (a_we)
      mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
  end

  // Lowest byte address of a word drives the most significant lane.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      b_rdata[OUT_BITS-1-8*i -: 8] <= mem[BAW'(int'(b_addr) * LANES + i)];
  end

endmodule

// File: rtl/seq_play_core.sv
// rtl/seq_play_core.sv - sequence player: register file, play FSM and pattern memory
module seq_play_core
  import seq_play_pkg::*;
#(
  parameter int MEM_BYTES = 8 * 1024,
  parameter int ABUSWIDTH = 16,
  parameter int OUT_BITS  = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 SEQ_EXT_START,
  output logic [OUT_BITS-1:0]  SEQ_OUT,
  output logic                 SEQ_OUT_VALID
);

  localparam int WORDS = calc_words(MEM_BYTES, OUT_BITS);
  localparam int BAW   = $clog2(MEM_BYTES);
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [15:0] COUNT_RST = 16'(WORDS);

  logic [31:0] add32;
  logic        in_mem, soft_rst, start;
  logic [1:0]  conf;
  logic [15:0] count, rep_cnt;
  logic [7:0]  scratch [9];
  logic [7:0]  reg_rdata, rd_data, mem_rdata;
  logic        rd_is_mem;

  assign add32    = 32'(BUS_ADD);
  assign in_mem   = (add32 >= MEM_BASE) && (add32 < MEM_BASE + MEM_BYTES);
  assign soft_rst = BUS_WR && (add32 == REG_VERSION);
  assign start    = BUS_WR && (add32 == REG_START);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      conf    <= '0;
      count   <= COUNT_RST;
      rep_cnt <= 16'd1;
      for (int i = 0; i < 9; i++) scratch[i] <= '0;
    end else if (soft_rst) begin
      conf    <= '0;
      count   <= COUNT_RST;
      rep_cnt <= 16'd1;
      for (int i = 0; i < 9; i++) scratch[i] <= '0;
    end else if (BUS_WR) begin
      case (add32)
        REG_CONF:     conf          <= BUS_DATA_IN[1:0];
        REG_COUNT_L:  count[7:0]    <= BUS_DATA_IN;
        REG_COUNT_H:  count[15:8]   <= BUS_DATA_IN;
        REG_REPEAT_L: rep_cnt[7:0]  <= BUS_DATA_IN;
        REG_REPEAT_H: rep_cnt[15:8] <= BUS_DATA_IN;
        default:
          if (add32 >= REG_SCR_LO && add32 <= REG_SCR_HI)
            scratch[4'(add32 - 32'(REG_SCR_LO))] <= BUS_DATA_IN;
      endcase
    end
  end

  play_state_t    state, state_next;
  logic [WAW-1:0] word_addr;
  logic [15:0]    pass_cnt;
  logic           done, out_valid, trig, at_end, more;
  logic [31:0]    eff;
  logic [OUT_BITS-1:0] play_word;

  always_comb begin
    reg_rdata = '0;
    case (add32)
      REG_VERSION:  reg_rdata = VERSION;
      REG_START:    reg_rdata = {7'b0, done};
      REG_CONF:     reg_rdata = {6'b0, conf};
      REG_COUNT_L:  reg_rdata = count[7:0];
      REG_COUNT_H:  reg_rdata = count[15:8];
      REG_REPEAT_L: reg_rdata = rep_cnt[7:0];
      REG_REPEAT_H: reg_rdata = rep_cnt[15:8];
      default:
        if (add32 >= REG_SCR_LO && add32 <= REG_SCR_HI)
          reg_rdata = scratch[4'(add32 - 32'(REG_SCR_LO))];
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      rd_is_mem <= 1'b0;
      rd_data   <= '0;
    end else if (BUS_RD) begin
      rd_is_mem <= in_mem;
      rd_data   <= reg_rdata;
    end
  end

  assign BUS_DATA_OUT = rd_is_mem ? mem_rdata : rd_data;

  assign eff    = (32'(count) < 32'(WORDS)) ? 32'(count) : 32'(WORDS);
  assign trig   = start || (SEQ_EXT_START && conf[0] && state != ST_RUN);
  assign at_end = (32'(word_addr) == eff - 32'd1);
  assign more   = conf[1] || (rep_cnt == 16'd0) || (pass_cnt < rep_cnt);

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (at_end && !more) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (trig)
      state_next = (eff == 32'd0) ? ST_IDLE : ST_RUN;
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state     <= ST_IDLE;
      word_addr <= '0;
      pass_cnt  <= '0;
      done      <= 1'b1;
      out_valid <= 1'b0;
    end else if (soft_rst) begin
      state     <= ST_IDLE;
      word_addr <= '0;
      pass_cnt  <= '0;
      done      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      // A word fetched in a RUN cycle is on the output one cycle later.
      out_valid <= (state == ST_RUN);
      if (trig) begin
        word_addr <= '0;
        pass_cnt  <= 16'd1;
        done      <= (eff == 32'd0);
      end else if (state == ST_RUN) begin
        word_addr <= at_end ? '0 : word_addr + 1'b1;
        if (at_end && more)
          pass_cnt <= pass_cnt + 16'd1;
      end else if (state == ST_DRAIN) begin
        done <= 1'b1;
      end
    end
  end

  seq_play_mem #(
    .MEM_BYTES(MEM_BYTES),
    .OUT_BITS (OUT_BITS)
  ) u_mem (
    .clk    (BUS_CLK),
    .a_we   (BUS_WR && in_mem),
    .a_addr (BAW'(add32 - 32'(MEM_BASE))),
    .a_wdata(BUS_DATA_IN),
    .a_rdata(mem_rdata),
    .b_addr (word_addr),
    .b_rdata(play_word)
  );

  assign SEQ_OUT       = out_valid ? play_word : '0;
  assign SEQ_OUT_VALID = out_valid;

endmodule

// File: tb/tb_seq_play_core.sv
// tb/tb_seq_play_core.sv - directed self-checking bench for seq_play_core
module tb_seq_play_core;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST = 1'b1;
  logic [15:0] BUS_ADD = '0;
  logic [7:0]  BUS_DATA_IN = '0;
  logic        BUS_RD = 1'b0;
  logic        BUS_WR = 1'b0;
  logic        SEQ_EXT_START = 1'b0;
  logic [7:0]  dout8, dout16;
  logic [7:0]  out8;
  logic [15:0] out16;
  logic        valid8, valid16;

  int checks = 0;
  int failures = 0;

  always #5 BUS_CLK = ~BUS_CLK;

  seq_play_core #(.MEM_BYTES(16), .ABUSWIDTH(16), .OUT_BITS(8)) dut8 (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_DATA_OUT(dout8), .SEQ_EXT_START(SEQ_EXT_START),
    .SEQ_OUT(out8), .SEQ_OUT_VALID(valid8)
  );

  seq_play_core #(.MEM_BYTES(16), .ABUSWIDTH(16), .OUT_BITS(16)) dut16 (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_DATA_OUT(dout16), .SEQ_EXT_START(SEQ_EXT_START),
    .SEQ_OUT(out16), .SEQ_OUT_VALID(valid16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic bus_write(input int a, input int d);
    BUS_ADD = 16'(a);
    BUS_DATA_IN = 8'(d);
    BUS_WR = 1'b1;
    tick();
    BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [7:0] d8, output logic [7:0] d16);
    BUS_ADD = 16'(a);
    BUS_RD = 1'b1;
    tick();
    BUS_RD = 1'b0;
    d8 = dout8;
    d16 = dout16;
  endtask

  task automatic start_cmd();
    BUS_ADD = 16'd1;
    BUS_WR = 1'b1;
    tick();
    BUS_WR = 1'b0;
  endtask

  logic [7:0] r8, r16;
  logic [7:0] reg_exp [7] = '{8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00};
  logic [7:0] pat4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] pat_ab [4] = '{8'hAB, 8'hCD, 8'h12, 8'h34};
  int nv8, nv16;

  initial begin
    tick();
    tick();
    check("rst_out8", 32'({valid8, out8}), 32'h0);
    check("rst_out16", 32'({valid16, out16}), 32'h0);
    BUS_RST = 1'b0;
    tick();

    for (int a = 0; a < 7; a++) begin
      bus_read(a, r8, r16);
      check($sformatf("reg_default_%0d", a), 32'(r8), 32'(reg_exp[a]));
    end
    bus_read(3, r8, r16);
    check("count_default16", 32'(r16), 32'h08);

    for (int k = 0; k < 4; k++) bus_write(16 + k, pat4[k]);
    bus_read(18, r8, r16);
    check("mem_readback", 32'(r8), 32'h33);
    bus_write(3, 4);
    start_cmd();
    check("basic_t1", 32'({valid8, out8}), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("basic_word%0d", k), 32'({valid8, out8}), 32'({1'b1, pat4[k]}));
    end
    tick();
    check("basic_end", 32'({valid8, out8}), 32'h0);
    bus_read(1, r8, r16);
    check("basic_done", 32'(r8), 32'h01);

    for (int k = 0; k < 4; k++) bus_write(16 + k, pat_ab[k]);
    bus_write(3, 2);
    bus_write(5, 3);
    start_cmd();
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("wide_word%0d", k), 32'({valid16, out16}),
            (k % 2 == 0) ? 32'h1ABCD : 32'h11234);
    end
    tick();
    check("wide_end", 32'({valid16, out16}), 32'h0);
    bus_read(1, r8, r16);
    check("wide_done", 32'(r16), 32'h01);

    bus_write(3, 4);
    bus_write(5, 1);
    SEQ_EXT_START = 1'b1;
    tick();
    SEQ_EXT_START = 1'b0;
    nv8 = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nv8 += int'(valid8);
    end
    check("ext_gated", 32'(nv8), 32'd0);
    bus_write(2, 1);
    SEQ_EXT_START = 1'b1;
    tick();
    SEQ_EXT_START = 1'b0;
    check("ext_t1", 32'({valid8, out8}), 32'h0);
    tick();
    check("ext_word0", 32'({valid8, out8}), 32'h1AB);
    SEQ_EXT_START = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      SEQ_EXT_START = 1'b0;
      check($sformatf("ext_word%0d", k), 32'({valid8, out8}), 32'({1'b1, pat_ab[k]}));
    end
    tick();
    check("ext_end", 32'({valid8, out8}), 32'h0);
    bus_write(2, 0);

    bus_write(3, 3);
    bus_write(2, 2);
    BUS_ADD = 16'd1;
    BUS_WR = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) BUS_WR = 1'b0;
      if (c == 10) begin
        BUS_ADD = 16'd2;
        BUS_DATA_IN = 8'd0;
        BUS_WR = 1'b1;
      end
      if (c == 11) BUS_WR = 1'b0;
      check($sformatf("loop_c%0d", c), 32'({valid8, out8}),
            (c >= 2 && c <= 13) ? 32'({1'b1, pat_ab[(c - 2) % 3]}) : 32'h0);
    end
    bus_read(1, r8, r16);
    check("loop_done", 32'(r8), 32'h01);

    bus_write(2, 2);
    start_cmd();
    for (int c = 2; c <= 5; c++) tick();
    check("abort_pre", 32'({valid8, out8}), 32'h1AB);
    BUS_ADD = 16'd0;
    BUS_WR = 1'b1;
    tick();
    BUS_WR = 1'b0;
    check("abort_out", 32'({valid8, out8}), 32'h0);
    bus_read(3, r8, r16);
    check("abort_count8", 32'(r8), 32'h10);
    check("abort_count16", 32'(r16), 32'h08);
    bus_read(2, r8, r16);
    check("abort_conf", 32'(r8), 32'h00);
    bus_read(1, r8, r16);
    check("abort_done", 32'(r8), 32'h01);

    bus_write(3, 0);
    start_cmd();
    BUS_ADD = 16'd1;
    BUS_RD = 1'b1;
    nv8 = int'(valid8);
    tick();
    BUS_RD = 1'b0;
    check("cnt0_done", 32'(dout8), 32'h01);
    for (int k = 0; k < 3; k++) begin
      nv8 += int'(valid8);
      tick();
    end
    check("cnt0_novalid", 32'(nv8), 32'd0);

    bus_write(3, 8'hFF);
    bus_write(4, 8'hFF);
    start_cmd();
    nv8 = 0;
    nv16 = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      nv8 += int'(valid8);
      nv16 += int'(valid16);
    end
    check("cntmax_words8", 32'(nv8), 32'd16);
    check("cntmax_words16", 32'(nv16), 32'd8);

    start_cmd();
    tick();
    tick();
    check("arst_pre", 32'(valid8), 32'h1);
    #2;
    BUS_RST = 1'b1;
    #1;
    check("arst_out8", 32'({valid8, out8}), 32'h0);
    check("arst_out16", 32'({valid16, out16}), 32'h0);
    tick();
    BUS_RST = 1'b0;
    tick();
    bus_read(4, r8, r16);
    check("arst_count_h", 32'(r8), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
